// File: rtl/ram_cmd_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM command arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    WAIT = 2'd3
  } arb_state_e;

  // Top two bits of the RAM command word select the command kind.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Requester index to one-hot response strobe.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_cmd_arbiter_if.sv
// Requester and RAM-side signal bundle of the command arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester; responses and RAM side have none.
interface ram_cmd_arbiter_if #(
  parameter int ADDR_SIZE = 8
);

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_wr;
  logic [1:0][ADDR_SIZE-1:0]  req_addr;
  logic [1:0][ADDR_SIZE-1:0]  req_wdata;
  logic [1:0]                 rsp_valid;
  logic [ADDR_SIZE-1:0]       rsp_data;
  logic                       rsp_err;
  logic [ADDR_SIZE+1:0]       ram_din;
  logic                       ram_rx_valid;
  logic                       ram_tx_valid;
  logic [ADDR_SIZE-1:0]       ram_dout;

  // Arbiter side.
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, ram_tx_valid, ram_dout,
    output req_ready, rsp_valid, rsp_data, rsp_err, ram_din, ram_rx_valid
  );

  // Requesters plus RAM, seen from outside the arbiter.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, ram_tx_valid, ram_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_err, ram_din, ram_rx_valid
  );

endinterface

// File: rtl/ram_cmd_arbiter_rr.sv
// Two-way round-robin grant with a remembered last-granted requester.
// Latency: grant is combinational; last-granted updates on the enabled edge.
// Backpressure: none; the caller qualifies the update with its accept.
module rr_arbiter_2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd_en,
  output logic [1:0] o_grant
);

  logic r_last;

  // A lone request wins outright; a tie goes to whoever was not granted last.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Remember the winner; reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      r_last <= 1'b1;
    else if (i_upd_en) r_last <= o_grant[1];
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares the RAM command port between two requesters; expands each transaction to two command words.
// Latency: commands at T+1/T+2 after accept; read response at T+4 (T+3+TIMEOUT with RAM_ARB_TIMEOUT_EN on a stall).
// Backpressure: req_ready only in IDLE for the granted requester; responses cannot be stalled.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ram_cmd_arbiter_if.slave bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  arb_state_e           r_state;
  arb_state_e           w_next;
  logic                 r_wr;
  logic                 r_owner;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [ADDR_SIZE-1:0] r_wdata;
  logic [1:0]           r_rsp_valid;
  logic [ADDR_SIZE-1:0] r_rsp_data;
  logic [1:0]           w_grant;
  logic [1:0]           w_ready;
  logic                 w_accept;
  logic                 w_timeout;

  rr_arbiter_2 u_rr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (bus.req_valid),
    .i_upd_en (w_accept),
    .o_grant  (w_grant)
  );

  assign w_accept = |(bus.req_valid & w_ready);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;

  // Cycles spent in WAIT; held at zero elsewhere so it is clear on entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || r_state != WAIT) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout   = (r_state == WAIT) && !bus.ram_tx_valid && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state: fixed two-command walk, reads then park in WAIT for data.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ADDR;
      ADDR:    w_next = DATA;
      DATA:    w_next = r_wr ? IDLE : WAIT;
      WAIT:    if (bus.ram_tx_valid || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: accept handshake in IDLE, command words in ADDR/DATA.
  always_comb begin
    w_ready          = 2'b00;
    bus.ram_rx_valid = 1'b0;
    bus.ram_din      = '0;
    case (r_state)
      IDLE: if (i_rst_n) w_ready = w_grant;
      ADDR: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {(r_wr ? CMD_WR_ADDR : CMD_RD_ADDR), r_addr};
      end
      DATA: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = r_wr ? {CMD_WR_DATA, r_wdata} : {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
      end
      default: ;
    endcase
  end

  assign bus.req_ready = w_ready;

  // Capture the winning payload only on the accept edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr    <= 1'b0;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= bus.req_wr[w_grant[1]];
      r_owner <= w_grant[1];
      r_addr  <= bus.req_addr[w_grant[1]];
      r_wdata <= bus.req_wdata[w_grant[1]];
    end
  end

  // Single-cycle response strobe to the owner, on read data or timeout.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 2'b00;
      if (r_state == WAIT && bus.ram_tx_valid) begin
        r_rsp_valid <= onehot2(r_owner);
        r_rsp_data  <= bus.ram_dout;
`ifdef RAM_ARB_TIMEOUT_EN
        r_rsp_err   <= 1'b0;
`endif
      end else if (w_timeout) begin
        r_rsp_valid <= onehot2(r_owner);
        r_rsp_data  <= {ADDR_SIZE{1'b1}};
`ifdef RAM_ARB_TIMEOUT_EN
        r_rsp_err   <= 1'b1;
`endif
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with a small behavioural RAM on the command port.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_cmd_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ram_en = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  ram_cmd_arbiter_if #(.ADDR_SIZE(8)) bus ();

  ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // RAM model: address word then data word; read data valid the cycle after the read-data command.
  logic [7:0] mem [256];
  logic [7:0] wa;
  logic [7:0] ra;
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.ram_tx_valid <= 1'b0;
      bus.ram_dout     <= 8'h00;
    end else begin
      bus.ram_tx_valid <= 1'b0;
      if (bus.ram_rx_valid) begin
        case (bus.ram_din[9:8])
          2'b00: wa <= bus.ram_din[7:0];
          2'b01: mem[wa] <= bus.ram_din[7:0];
          2'b10: ra <= bus.ram_din[7:0];
          default: begin
            bus.ram_tx_valid <= ram_en;
            bus.ram_dout     <= mem[ra];
          end
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_wr    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset, with both requests pending: nothing may be accepted.
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    cyc(); cyc(); #1;
    chk("rst_req_ready", 16'(bus.req_ready), 16'h0);
    chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
    chk("rst_rsp_data", 16'(bus.rsp_data), 16'h0);
    chk("rst_rsp_err", 16'(bus.rsp_err), 16'h0);
    chk("rst_ram_din", 16'(bus.ram_din), 16'h0);
    chk("rst_ram_rx_valid", 16'(bus.ram_rx_valid), 16'h0);

    // Req0 write 0x3C <- 0xA5; payload changed after accept must not matter.
    cyc();
    rst_n = 1'b1;
    bus.req_valid = 2'b01; bus.req_wr = 2'b01;
    bus.req_addr[0] = 8'h3C; bus.req_wdata[0] = 8'hA5;
    #1 chk("wr_ready", 16'(bus.req_ready), 16'h1);
    cyc();
    bus.req_valid = 2'b00; bus.req_addr[0] = 8'h55; bus.req_wdata[0] = 8'h66;
    #1 chk("wr_addr_din", 16'(bus.ram_din), 16'h03C);
    chk("wr_addr_rx", 16'(bus.ram_rx_valid), 16'h1);
    cyc(); #1;
    chk("wr_data_din", 16'(bus.ram_din), 16'h1A5);
    chk("wr_data_rx", 16'(bus.ram_rx_valid), 16'h1);

    // Back in IDLE: req1 reads 0x3C.
    cyc();
    bus.req_valid = 2'b10; bus.req_wr = 2'b00; bus.req_addr[1] = 8'h3C;
    #1 chk("wr_idle_rx", 16'(bus.ram_rx_valid), 16'h0);
    chk("wr_idle_din", 16'(bus.ram_din), 16'h0);
    chk("wr_no_rsp", 16'(bus.rsp_valid), 16'h0);
    chk("rd1_ready", 16'(bus.req_ready), 16'h2);
    cyc();
    bus.req_valid = 2'b00; bus.req_addr[1] = 8'h00;
    #1 chk("rd1_addr_din", 16'(bus.ram_din), 16'h23C);
    cyc(); #1;
    chk("rd1_data_din", 16'(bus.ram_din), 16'h300);
    cyc(); #1;
    chk("rd1_wait_rsp", 16'(bus.rsp_valid), 16'h0);
    chk("rd1_wait_rx", 16'(bus.ram_rx_valid), 16'h0);
    cyc(); #1;
    chk("rd1_rsp_valid", 16'(bus.rsp_valid), 16'h2);
    chk("rd1_rsp_data", 16'(bus.rsp_data), 16'hA5);
    chk("rd1_rsp_err", 16'(bus.rsp_err), 16'h0);
    cyc(); #1;
    chk("rd1_rsp_one_cycle", 16'(bus.rsp_valid), 16'h0);

    // Fresh reset, then both requesters read continuously: grants alternate from 0.
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    bus.req_valid = 2'b11; bus.req_wr = 2'b00;
    bus.req_addr[0] = 8'h3C; bus.req_addr[1] = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", 16'(bus.req_ready), (k % 2 == 0) ? 16'h1 : 16'h2);
      if (k > 0) begin
        chk("rr_rsp_owner", 16'(bus.rsp_valid), (k % 2 == 0) ? 16'h2 : 16'h1);
        chk("rr_rsp_data", 16'(bus.rsp_data), 16'hA5);
      end
      cyc(); cyc(); cyc(); cyc();
    end
    bus.req_valid = 2'b00;
    #1 chk("rr_last_rsp", 16'(bus.rsp_valid), 16'h2);

    // Reset asserted during DATA of a req0 read: transaction dropped.
    cyc();
    bus.req_valid = 2'b01; bus.req_wr = 2'b00; bus.req_addr[0] = 8'h3C;
    #1 chk("drop_ready", 16'(bus.req_ready), 16'h1);
    cyc();
    bus.req_valid = 2'b00;
    cyc(); #1;
    chk("drop_data_din", 16'(bus.ram_din), 16'h300);
    rst_n = 1'b0;
    bus.req_valid = 2'b01;
    cyc(); #1;
    chk("drop_rx", 16'(bus.ram_rx_valid), 16'h0);
    chk("drop_din", 16'(bus.ram_din), 16'h0);
    chk("drop_rsp", 16'(bus.rsp_valid), 16'h0);
    chk("drop_ready_in_rst", 16'(bus.req_ready), 16'h0);
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    cyc(); #1;
    chk("drop_no_rsp1", 16'(bus.rsp_valid), 16'h0);
    chk("drop_no_cmd", 16'(bus.ram_rx_valid), 16'h0);
    cyc(); #1;
    chk("drop_no_rsp2", 16'(bus.rsp_valid), 16'h0);

`ifdef RAM_ARB_TIMEOUT_EN
    // RAM never answers: error response after TIMEOUT cycles in WAIT.
    ram_en = 1'b0;
    bus.req_valid = 2'b01; bus.req_wr = 2'b00; bus.req_addr[0] = 8'h3C;
    #1 chk("to_ready", 16'(bus.req_ready), 16'h1);
    cyc();
    bus.req_valid = 2'b00;
    cyc(); cyc(); cyc(); cyc(); cyc(); #1;
    chk("to_not_yet", 16'(bus.rsp_valid), 16'h0);
    cyc(); #1;
    chk("to_rsp_valid", 16'(bus.rsp_valid), 16'h1);
    chk("to_rsp_err", 16'(bus.rsp_err), 16'h1);
    chk("to_rsp_data", 16'(bus.rsp_data), 16'hFF);
    ram_en = 1'b1;
    cyc();
`endif

    // Boundary address 0xFF: write 0x00 then read it back.
    bus.req_valid = 2'b01; bus.req_wr = 2'b01;
    bus.req_addr[0] = 8'hFF; bus.req_wdata[0] = 8'h00;
    #1 chk("ff_wr_ready", 16'(bus.req_ready), 16'h1);
    cyc();
    bus.req_valid = 2'b00;
    #1 chk("ff_wr_addr", 16'(bus.ram_din), 16'h0FF);
    cyc(); #1;
    chk("ff_wr_data", 16'(bus.ram_din), 16'h100);
    cyc();
    bus.req_valid = 2'b01; bus.req_wr = 2'b00;
    #1 chk("ff_rd_ready", 16'(bus.req_ready), 16'h1);
    cyc();
    bus.req_valid = 2'b00;
    #1 chk("ff_rd_addr", 16'(bus.ram_din), 16'h2FF);
    cyc(); #1;
    chk("ff_rd_data", 16'(bus.ram_din), 16'h300);
    cyc(); #1;
    chk("ff_wait", 16'(bus.rsp_valid), 16'h0);
    cyc(); #1;
    chk("ff_rsp_valid", 16'(bus.rsp_valid), 16'h1);
    chk("ff_rsp_data", 16'(bus.rsp_data), 16'h00);
    chk("ff_rsp_err", 16'(bus.rsp_err), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
